div_signed_ctrl: RTL and testbench
==================================

// Module: div_signed_ctrl
// PURPOSE
// - Upstream front end for the unsigned shift-subtract divider: valid/ready operand intake, optional signed mode.
// - Converts signed operands to magnitudes, sequences the divider's en/done protocol, restores result signs.
// - Presents the result on a valid/ready output. Sits between the CPU/accelerator request bus and the divider core.
// PARAMETERS
// - DATA_W  32  operand/result width in bits; must match the divider instance.
// PORTS
// - clk            in   1       clock; all logic on rising edge
// - rst            in   1       reset; synchronous, active-high
// - in_valid       in   1       operand request valid
// - in_ready       out  1       block can accept operands
// - in_signed      in   1       1 = two's-complement operands, 0 = unsigned
// - dividend       in   DATA_W  dividend
// - divisor        in   DATA_W  divisor
// - out_valid      out  1       result valid
// - out_ready      in   1       consumer accepts result
// - quotient       out  DATA_W  final quotient
// - remainder      out  DATA_W  final remainder
// - div_by_zero    out  1       result produced by the zero-divisor path
// - div_en         out  1       divider enable; held high for a whole operation
// - div_dividend   out  DATA_W  unsigned magnitude to the divider
// - div_divisor    out  DATA_W  unsigned magnitude to the divider
// - div_done       in   1       divider finished; level, stays high while div_en is high
// - div_quotient   in   DATA_W  unsigned quotient from the divider
// - div_remainder  in   DATA_W  unsigned remainder from the divider
// BEHAVIOUR
// - Reset: state=IDLE; in_ready=1; out_valid=0; div_en=0; quotient/remainder/div_by_zero=0.
// - Reset has priority over every event, including mid-RUN. div_en drops the same edge, which clears the divider.
// - FSM: IDLE -> RUN -> FIX -> OUT -> IDLE.
// - IDLE: in_ready=1, div_en=0.
//   - On in_valid&in_ready: register magnitudes and signs; go to RUN.
//   - Magnitudes: |x| = x when in_signed=0 or x[DATA_W-1]=0, else (~x+1) mod 2^DATA_W.
//   - Register sq = signed & (dvd_msb ^ dsr_msb) and sr = signed & dvd_msb.
// - RUN: div_en=1, in_ready=0.
//   - On the first cycle div_done=1: capture div_quotient/div_remainder; go to FIX. div_en=0 from that edge.
// - FIX: div_en=0.
//   - quotient = sq ? -q_raw : q_raw; remainder = sr ? -r_raw : r_raw. Truncate toward zero; remainder takes the dividend's sign.
//   - Go to OUT.
// - OUT: out_valid=1. Outputs stay stable until out_valid&out_ready, then return to IDLE.
// - Latency: div_en rises 1 cycle after accept. out_valid rises 2 cycles after div_done is first sampled high.
// - Throughput: one operation in flight. div_en is low for at least 2 cycles between operations, guaranteeing divider re-init.
// - Overflow: signed MIN / -1 wraps naturally: quotient=MIN, remainder=0, no flag.
// - Unsigned mode: no sign handling; all-ones operands are legal.
// - in_valid while busy is ignored (not accepted). Operands are sampled only on the accept edge.
// CONFIGURATION
// - DIV_SIGNED_ZERO_CHK_EN defined:
//   - divisor==0 at accept skips RUN (div_en stays 0) and goes IDLE->FIX.
//   - Result: quotient = all ones; remainder = original dividend (no sign transform); div_by_zero=1 in OUT.
//   - Total latency accept->out_valid = 2 cycles.
// - DIV_SIGNED_ZERO_CHK_EN undefined:
//   - Zero divisor runs through the divider unchanged, with the normal sign fix.
//   - div_by_zero is tied to 0.
// TESTING (DATA_W=32, divider model with done after DATA_W+2 en cycles)
// - Signed: dividend=-7 (0xFFFFFFF9), divisor=2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
// - Unsigned: dividend=0xFFFFFFF9, divisor=2 -> quotient 0x7FFFFFFC, remainder 1. Same operands signed=1 give the previous result.
// - Signed: 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero=0.
// - Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, new in_valid not accepted.
//   - Then out_ready=1 -> in_ready=1 next cycle.
// - Zero divisor, 100/0 with DIV_SIGNED_ZERO_CHK_EN -> div_en never rises, out_valid 2 cycles after accept, quotient 0xFFFFFFFF, remainder 100, div_by_zero=1.
// - rst pulsed 10 cycles into RUN -> next edge div_en=0, out_valid=0, in_ready=1.
//   - Following 9/3 request -> quotient 3, remainder 0.

Source files
------------

// File: rtl/div_signed_ctrl.sv
// rtl/div_signed_ctrl.sv - valid/ready signed front end for the unsigned shift-subtract divider
// Optional zero-divisor bypass: define DIV_SIGNED_ZERO_CHK_EN.
module div_signed_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero,
    output logic              div_en,
    output logic [DATA_W-1:0] div_dividend,
    output logic [DATA_W-1:0] div_divisor,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_quotient,
    input  logic [DATA_W-1:0] div_remainder
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_OUT
    } state_t;

    state_t            state;
    logic              sq;
    logic              sr;
    logic [DATA_W-1:0] q_raw;
    logic [DATA_W-1:0] r_raw;

    logic              dvd_neg;
    logic              dsr_neg;
    logic [DATA_W-1:0] dvd_mag;
    logic [DATA_W-1:0] dsr_mag;

    // Two's-complement negate wraps MIN onto itself, which the unsigned core handles as 2^(W-1).
    assign dvd_neg = in_signed & dividend[DATA_W-1];
    assign dsr_neg = in_signed & divisor[DATA_W-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dsr_mag = dsr_neg ? -divisor : divisor;

`ifdef DIV_SIGNED_ZERO_CHK_EN
    logic              zero_path;
    logic [DATA_W-1:0] dvd_raw;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            div_en       <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            sq           <= 1'b0;
            sr           <= 1'b0;
            q_raw        <= '0;
            r_raw        <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
`ifdef DIV_SIGNED_ZERO_CHK_EN
            zero_path    <= 1'b0;
            dvd_raw      <= '0;
            div_by_zero  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        div_dividend <= dvd_mag;
                        div_divisor  <= dsr_mag;
                        sq           <= dvd_neg ^ dsr_neg;
                        sr           <= dvd_neg;
                        in_ready     <= 1'b0;
`ifdef DIV_SIGNED_ZERO_CHK_EN
                        dvd_raw      <= dividend;
                        div_by_zero  <= 1'b0;
                        if (divisor == '0) begin
                            zero_path <= 1'b1;
                            state     <= S_FIX;
                        end else begin
                            zero_path <= 1'b0;
                            div_en    <= 1'b1;
                            state     <= S_RUN;
                        end
`else
                        div_en       <= 1'b1;
                        state        <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    if (div_done) begin
                        q_raw  <= div_quotient;
                        r_raw  <= div_remainder;
                        div_en <= 1'b0;
                        state  <= S_FIX;
                    end
                end
                S_FIX: begin
`ifdef DIV_SIGNED_ZERO_CHK_EN
                    if (zero_path) begin
                        quotient    <= '1;
                        remainder   <= dvd_raw;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient  <= sq ? -q_raw : q_raw;
                        remainder <= sr ? -r_raw : r_raw;
                    end
`else
                    quotient  <= sq ? -q_raw : q_raw;
                    remainder <= sr ? -r_raw : r_raw;
`endif
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_signed_ctrl.sv
// tb/tb_div_signed_ctrl.sv - self-checking bench for div_signed_ctrl with a behavioural divider core
module tb_div_signed_ctrl;

    localparam int DATA_W = 32;
    localparam int LIM    = DATA_W + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_signed;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              div_by_zero;
    logic              div_en;
    logic [DATA_W-1:0] div_dividend;
    logic [DATA_W-1:0] div_divisor;
    logic              div_done;
    logic [DATA_W-1:0] div_quotient;
    logic [DATA_W-1:0] div_remainder;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_signed_ctrl #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .div_en(div_en), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    // Behavioural unsigned divider: done after LIM enabled cycles, cleared when en drops.
    int en_cnt;
    always_ff @(posedge clk) begin
        if (!div_en) en_cnt <= 0;
        else if (en_cnt < LIM) en_cnt <= en_cnt + 1;
    end
    assign div_done      = div_en && (en_cnt == LIM);
    assign div_quotient  = (div_divisor == '0) ? '1 : div_dividend / div_divisor;
    assign div_remainder = (div_divisor == '0) ? div_dividend : div_dividend % div_divisor;

    function automatic void chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endfunction

    // Reference: plain integer division with truncation toward zero.
    function automatic void ref_div(input logic s, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                    output logic [DATA_W-1:0] q, output logic [DATA_W-1:0] r, output logic z);
        longint sa, sb;
        z = 1'b0;
        if (b == '0) begin
`ifdef DIV_SIGNED_ZERO_CHK_EN
            q = '1; r = a; z = 1'b1;
`else
            q = (s && a[DATA_W-1]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
`endif
        end else if (!s) begin
            q = a / b; r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    task automatic do_op(input string nm, input logic s, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input int hold, input logic [DATA_W-1:0] eq, input logic [DATA_W-1:0] er, input logic ez);
        int idx, first_done, out_idx;
        logic zp, en_seen;
        logic [DATA_W-1:0] q0, r0;
`ifdef DIV_SIGNED_ZERO_CHK_EN
        zp = (b == '0);
`else
        zp = 1'b0;
`endif
        @(negedge clk);
        chk({nm, "_in_ready_idle"}, in_ready, 1);
        in_valid = 1; in_signed = s; dividend = a; divisor = b;
        @(posedge clk);
        #1;
        in_valid = 0; dividend = $urandom; divisor = $urandom; in_signed = $urandom_range(0, 1);
        first_done = -1; out_idx = -1; en_seen = 0;
        for (idx = 1; idx < 200; idx++) begin
            @(negedge clk);
            if (idx == 1) chk({nm, "_div_en_after_accept"}, div_en, !zp);
            if (div_en) en_seen = 1;
            if (div_done && first_done < 0) first_done = idx;
            if (out_valid) begin out_idx = idx; break; end
        end
        if (out_idx < 0) begin
            chk({nm, "_timeout"}, 0, 1);
            return;
        end
        if (zp) begin
            chk({nm, "_zero_latency"}, out_idx, 2);
            chk({nm, "_zero_no_en"}, en_seen, 0);
        end else begin
            chk({nm, "_latency"}, out_idx, first_done + 2);
        end
        chk({nm, "_quotient"}, quotient, eq);
        chk({nm, "_remainder"}, remainder, er);
        chk({nm, "_div_by_zero"}, div_by_zero, ez);
        q0 = quotient; r0 = remainder;
        in_valid = 1; in_signed = 0; dividend = 5; divisor = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, "_bp_quotient"}, quotient, q0);
            chk({nm, "_bp_remainder"}, remainder, r0);
            chk({nm, "_bp_out_valid"}, out_valid, 1);
            chk({nm, "_bp_in_ready"}, in_ready, 0);
            chk({nm, "_bp_no_accept"}, div_en, 0);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        chk({nm, "_in_ready_after"}, in_ready, 1);
        chk({nm, "_out_valid_after"}, out_valid, 0);
    endtask

    typedef struct {
        logic              s;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] r;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [DATA_W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return $urandom_range(1, 20);
            4: return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [DATA_W-1:0] rq, rr, rb, ra;
        logic rz, rs;

        vecs[0] = '{1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[1] = '{1'b0, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 32'd1};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        32'd0};
        vecs[4] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
        vecs[5] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF};
        vecs[6] = '{1'b0, 32'd100,       32'd7,        32'd14,       32'd2};
        vecs[7] = '{1'b0, 32'd3,         32'd9,        32'd0,        32'd3};

        rst = 1; in_valid = 0; in_signed = 0; dividend = 0; divisor = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_div_en", div_en, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        rst = 0;

        foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
                                (i == 0) ? 5 : 0, vecs[i].q, vecs[i].r, 1'b0);

`ifdef DIV_SIGNED_ZERO_CHK_EN
        do_op("zero_div", 1'b0, 32'd100, 32'd0, 2, 32'hFFFF_FFFF, 32'd100, 1'b1);
`else
        do_op("zero_div", 1'b0, 32'd100, 32'd0, 2, 32'hFFFF_FFFF, 32'd100, 1'b0);
`endif

        // Reset mid-RUN, then a clean operation.
        @(negedge clk);
        in_valid = 1; in_signed = 1; dividend = 32'd50; divisor = 32'd7;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (10) @(negedge clk);
        chk("midrun_div_en_high", div_en, 1);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("midrun_rst_div_en", div_en, 0);
        chk("midrun_rst_out_valid", out_valid, 0);
        chk("midrun_rst_in_ready", in_ready, 1);
        do_op("after_rst", 1'b0, 32'd9, 32'd3, 0, 32'd3, 32'd0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rs = $urandom_range(0, 1);
            ra = pick();
            rb = pick();
            ref_div(rs, ra, rb, rq, rr, rz);
            do_op($sformatf("rand%0d", n), rs, ra, rb, $urandom_range(0, 2), rq, rr, rz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
